// File: rtl/serial_subtractor4_if.sv
// serial_subtractor4_if: start/busy/done handshake and operand/result bus
// for the bit-serial subtractor. The controller side uses the master
// modport, the subtractor uses the slave modport.
// Optional build macro: SUB_OVF_FLAG_EN adds the signed-overflow flag (ovf).
interface serial_subtractor4_if #(
    parameter int WIDTH = 4
);
    // Request side: driven by the controller.
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;

    // Status and result side: driven by the subtractor.
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             bout;
`ifdef SUB_OVF_FLAG_EN
    logic             ovf;
`endif

    modport master (
        output start, A, B, bin,
        input  busy, done, D, bout
`ifdef SUB_OVF_FLAG_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, A, B, bin,
        output busy, done, D, bout
`ifdef SUB_OVF_FLAG_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor4.sv
// serial_subtractor4: bit-serial subtractor, D = A - B - bin.
// Each operation takes WIDTH clocks. On every RUN clock one full-subtractor
// cell handles the low bit of the operand shift registers and a flop holds
// the borrow. The difference bit enters the result register from the MSB
// side, so after WIDTH shifts the full result is in place. A new request
// is taken in IDLE or in the DONE cycle, which allows back-to-back
// operations at one every WIDTH+1 cycles. A request that arrives during
// RUN is dropped, not queued.
// Optional build macro: SUB_OVF_FLAG_EN adds a registered signed-overflow
// flag computed from the captured operand MSBs.
module serial_subtractor4 #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_subtractor4_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             br;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;

    // Registered outputs.
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;

`ifdef SUB_OVF_FLAG_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_q;
`endif

    // The one full-subtractor cell, working on the current low operand bits.
    logic a_i;
    logic b_i;
    logic d_bit;
    logic br_next;
    logic accept;

    assign a_i     = a_sr[0];
    assign b_i     = b_sr[0];
    assign d_bit   = a_i ^ b_i ^ br;
    assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);

    // A start is honoured in IDLE and DONE only. In RUN it is ignored.
    assign accept  = bus.start && (state != RUN);

    // Control FSM and serial datapath share one sequential process.
    // NOTE: all state updates use non-blocking assignment so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath shift registers are reset as well. A reset
            // during RUN then leaves no stale operand bits for the next
            // operation to pick up.
            state  <= IDLE;
            count  <= '0;
            br     <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            // Capture the operands and the borrow-in, then start the bit walk.
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            br     <= bus.bin;
            count  <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
            done_q <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            a_msb  <= bus.A[WIDTH-1];
            b_msb  <= bus.B[WIDTH-1];
`endif
        end else begin
            case (state)
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    br     <= br_next;
                    count  <= count + CW'(1);
                    if (count == LAST_BIT) begin
                        // Last bit: publish the result and pulse done for one cycle.
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        d_q    <= {d_bit, res_sr[WIDTH-1:1]};
                        bout_q <= br_next;
`ifdef SUB_OVF_FLAG_EN
                        // Operand signs differ and the result sign differs from A.
                        ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                    end
                end
                DONE: begin
                    // No new request in the done cycle, so return to IDLE.
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                IDLE: begin
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.D    = d_q;
    assign bus.bout = bout_q;
`ifdef SUB_OVF_FLAG_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
